fp_expander: RTL and testbench
==============================

FP_EXPANDER -- requirements
Module: fp_expander

Interface
REQ-001 Parameter OUT_W, default 12: width of the two's-complement output; SHALL be at least 12.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  a float code is presented on S/E/F.
REQ-005 in_ready  output  1  block can accept a code.
REQ-006 S  input  1  sign bit (1 = negative).
REQ-007 E  input  3  exponent, range 0..7.
REQ-008 F  input  4  significand, range 0..15.
REQ-009 out_valid  output  1  D holds a completed result.
REQ-010 out_ready  input  1  downstream consumes D.
REQ-011 D  output  OUT_W  linear value in two's complement, value = (-1)^S * F * 2^E.

Function
REQ-012 Acceptance SHALL happen on a rising edge where in_valid=1 and in_ready=1; S, E and F SHALL be captured on that edge.
REQ-013 in_ready SHALL be 1 only in state IDLE.
REQ-014 States SHALL be IDLE, SHIFT, SIGN and DONE.
REQ-015 State transitions:
- IDLE->SHIFT on acceptance; mag=F zero-extended to 11 bits, cnt=E, sgn=S.
- SHIFT with cnt!=0: mag<<=1, cnt-=1, stay in SHIFT.
- SHIFT with cnt=0: go to SIGN.
- SIGN: D=sgn ? -mag : mag, sign-extended to OUT_W; go to DONE.
- DONE->IDLE on a rising edge with out_ready=1.
REQ-016 out_valid SHALL be 1 exactly while in DONE.
REQ-017 Latency: out_valid SHALL rise on the (E+2)th rising edge after the acceptance edge, giving 2..9 cycles.
REQ-018 Maximum magnitude is 15*2^7 = 1920; mag SHALL be 11 bits and no overflow SHALL be possible.
REQ-019 A negative zero (S=1, F=0) SHALL produce D=0.
REQ-020 While in DONE with out_ready=0:
- D and out_valid SHALL hold stable.
- in_valid SHALL be ignored and no code captured.
REQ-021 D SHALL retain its last value after the DONE->IDLE handshake until the next SIGN state overwrites it.
REQ-022 out_ready asserted outside DONE SHALL have no effect.
REQ-023 Changes on S/E/F after acceptance SHALL NOT affect the result in flight.

Reset
REQ-024 While rst=1, the block SHALL asynchronously go to IDLE with D=0, out_valid=0, in_ready=1, and mag, cnt and sgn all 0.
REQ-025 A reset asserted mid-operation (SHIFT, SIGN or DONE) SHALL abort the operation and discard its result.
REQ-026 After rst is released, the first acceptance SHALL be possible on the next rising edge.

Structure
REQ-027 A shared package fp_pkg SHALL hold:
- the state encodings IDLE/SHIFT/SIGN/DONE;
- the constants EXP_W=3, SIG_W=4 and MAG_W=11.
REQ-028 One combinational sub-module, fp_negate, SHALL produce the OUT_W-bit two's-complement result from sgn and mag; all sequential logic stays in fp_expander.

Verification
REQ-029 Positive maximum: S=0, E=7, F=15 -> D=0x780 (1920), out_valid rises 9 edges after acceptance.
REQ-030 Negative value: S=1, E=3, F=10 -> D=0xFB0 (-80), latency 5.
REQ-031 Negative zero at minimum latency: S=1, E=0, F=0 -> D=0x000, latency 2.
REQ-032 Backpressure: out_ready=0 for 4 cycles in DONE while in_valid=1 with a new code -> D stable, in_ready=0, new code not captured; after out_ready=1, IDLE follows on the next edge.
REQ-033 Reset mid-operation: accept E=7, F=15, assert rst 3 cycles later -> immediately D=0, out_valid=0, in_ready=1; no result appears afterwards.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the small-float expander.
//   state_t : controller states (IDLE, SHIFT, SIGN, DONE)
//   EXP_W   : exponent width of the input code
//   SIG_W   : significand width of the input code
//   MAG_W   : width of the unsigned magnitude; holds 15 * 2^7 = 1920 exactly
package fp_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned MAG_W = 11;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_t;

endpackage

// File: rtl/fp_negate.sv
// Combinational sign application: zero-extends the magnitude to OUT_W bits
// and negates it in two's complement when sgn is set.
//   sgn : 1 = negative result
//   mag : unsigned magnitude (MAG_W bits)
//   res : OUT_W-bit two's-complement result
module fp_negate
  import fp_pkg::*;
#(
  parameter int unsigned OUT_W = 12
) (
  input  logic             sgn,
  input  logic [MAG_W-1:0] mag,
  output logic [OUT_W-1:0] res
);

  logic [OUT_W-1:0] ext;

  // A negative zero negates to zero, so no special case is needed.
  always_comb begin
    ext = OUT_W'(mag);
    res = sgn ? -ext : ext;
  end

endmodule

// File: rtl/fp_expander.sv
// Expands a sign/exponent/significand float code into a linear
// two's-complement value D = (-1)^S * F * 2^E, one shift per clock.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : code present on S/E/F
//   in_ready  : block idle, can accept a code
//   S, E, F   : sign, exponent, significand of the code
//   out_valid : D holds a completed result (held until out_ready)
//   out_ready : downstream consumes D
//   D         : OUT_W-bit two's-complement result, retained until overwritten
module fp_expander
  import fp_pkg::*;
#(
  parameter int unsigned OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [EXP_W-1:0] E,
  input  logic [SIG_W-1:0] F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D
);

  state_t           state;
  state_t           state_nx;
  logic [MAG_W-1:0] mag;
  logic [EXP_W-1:0] cnt;
  logic             sgn;
  logic [OUT_W-1:0] signed_val;
  logic             accept;

  assign accept = in_valid && in_ready;

  fp_negate #(
    .OUT_W(OUT_W)
  ) u_negate (
    .sgn(sgn),
    .mag(mag),
    .res(signed_val)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept) state_nx = SHIFT;
      SHIFT: if (cnt == '0) state_nx = SIGN;
      SIGN:  state_nx = DONE;
      DONE:  if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture, shift, and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      D   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mag <= MAG_W'(F);
            cnt <= E;
            sgn <= S;
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end
        end
        SIGN:    D <= signed_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_expander.sv
module tb_fp_expander;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D;

  int n_assert;
  int n_fail;
  int lat;
  int hits;
  logic [11:0] held_d;

  fp_expander #(
    .OUT_W(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .S(S),
    .E(E),
    .F(F),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .D(D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one code (caller is between edges), accepts it, scrambles the
  // inputs, then waits (bounded) for out_valid and checks latency and D.
  task automatic run(input string tag, input logic s, input logic [2:0] e,
                     input logic [3:0] f, input logic [11:0] exp_d, input logic hold_ready);
    in_valid  = 1'b1;
    S         = s;
    E         = e;
    F         = f;
    out_ready = hold_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    S = ~s;
    E = ~e;
    F = ~f;
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    check({tag, "_lat"}, 32'(lat), 32'(e) + 32'd2);
    check({tag, "_d"}, 32'(D), 32'(exp_d));
  endtask

  // Completes the output handshake and checks that D is retained.
  task automatic consume(input string tag, input logic [11:0] exp_d);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    check({tag, "_idle_vld"}, 32'(out_valid), 32'd0);
    check({tag, "_keep_d"}, 32'(D), 32'(exp_d));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    S = 1'b0;
    E = '0;
    F = '0;
    #1;
    check("rst_d", 32'(D), 32'd0);
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_rdy", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);

    // Release reset and accept on the very next edge
    @(negedge clk);
    rst = 1'b0;
    run("pos_max", 1'b0, 3'd7, 4'd15, 12'h780, 1'b0);
    consume("pos_max", 12'h780);

    run("neg80", 1'b1, 3'd3, 4'd10, 12'hFB0, 1'b0);
    consume("neg80", 12'hFB0);

    run("negzero", 1'b1, 3'd0, 4'd0, 12'h000, 1'b0);
    consume("negzero", 12'h000);

    run("one", 1'b0, 3'd0, 4'd1, 12'h001, 1'b0);
    consume("one", 12'h001);

    run("neg_max", 1'b1, 3'd7, 4'd15, 12'h880, 1'b0);
    consume("neg_max", 12'h880);

    // out_ready held high throughout: DONE lasts exactly one cycle
    @(negedge clk);
    run("rdy_hi", 1'b0, 3'd4, 4'd5, 12'h050, 1'b1);
    @(posedge clk);
    #1;
    check("rdy_hi_idle", 32'(in_ready), 32'd1);
    check("rdy_hi_keep", 32'(D), 32'h050);
    @(negedge clk);
    out_ready = 1'b0;

    // Backpressure with a competing code on the input
    run("bp", 1'b1, 3'd2, 4'd9, 12'hFDC, 1'b0);
    held_d = D;
    @(negedge clk);
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd1;
    F = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("bp_d_stable", 32'(D), 32'(held_d));
      check("bp_vld", 32'(out_valid), 32'd1);
      check("bp_rdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_vld_low", 32'(out_valid), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) hits++;
    end
    check("bp_no_capture", 32'(hits), 32'd0);
    check("bp_keep_d", 32'(D), 32'hFDC);

    // Reset in the middle of a long shift
    @(negedge clk);
    in_valid = 1'b1;
    S = 1'b0;
    E = 3'd7;
    F = 4'd15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_d", 32'(D), 32'd0);
    check("mid_rst_vld", 32'(out_valid), 32'd0);
    check("mid_rst_rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    hits = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) hits++;
    end
    check("mid_rst_no_result", 32'(hits), 32'd0);
    check("mid_rst_d_hold", 32'(D), 32'd0);

    // Normal operation after the abort
    @(negedge clk);
    run("post_rst", 1'b0, 3'd2, 4'd3, 12'h00C, 1'b0);
    consume("post_rst", 12'h00C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
